// File: rtl/delay_catch_buffer.sv
// Catch FIFO for words emerging from a fixed-latency delay line, with credit-based issue control.
// Optional DELAY_CATCH_LATENCY_CHECK_EN: flag any pipe_valid that does not line up with an issue DELAYS clocks earlier.
module delay_catch_buffer #(
  parameter int WIDTH  = 8,
  parameter int DELAYS = 2,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             pipe_valid,
  input  logic [WIDTH-1:0] pipe_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_inflight;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_err;

  logic [CW:0] w_credit_used;
  logic        w_issue;
  logic        w_arrive;
  logic        w_pop;
  logic        w_proto_err;
  logic        w_lat_err;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits count both held words and words still in the external pipeline,
  // so every issued word is guaranteed a slot when it emerges.
  assign w_credit_used = {1'b0, r_count} + {1'b0, r_inflight};
  assign issue_ready   = (w_credit_used < (CW+1)'(DEPTH));

  assign w_issue     = issue_valid & issue_ready;
  assign w_arrive    = pipe_valid & (r_inflight != '0) & (r_count != CW'(DEPTH));
  assign w_pop       = out_valid & out_ready;
  assign w_proto_err = pipe_valid & ~w_arrive;

  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign err       = r_err;

`ifdef DELAY_CATCH_LATENCY_CHECK_EN
  logic [DELAYS-1:0] r_iss_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_sr <= '0;
    end else begin
      r_iss_sr[0] <= w_issue;
      for (int i = 1; i < DELAYS; i++) r_iss_sr[i] <= r_iss_sr[i-1];
    end
  end

  // Top bit is the issue made DELAYS clocks ago: early and late arrivals both disagree with it.
  assign w_lat_err = (pipe_valid != r_iss_sr[DELAYS-1]);
`else
  assign w_lat_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      unique case ({w_issue, w_arrive})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      unique case ({w_arrive, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_arrive) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)    r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  // Storage needs no reset: out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (w_arrive) r_mem[r_wr_ptr] <= pipe_data;
  end

  always_ff @(posedge clk) begin
    if (rst)                          r_err <= 1'b0;
    else if (w_proto_err | w_lat_err) r_err <= 1'b1;
  end

endmodule
